// File: rtl/switch_debouncer_if.sv
// Switch debouncer signal bundle: raw switch levels and tick in, debounced value and change strobe out.
interface switch_debouncer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             tick;
  logic [WIDTH-1:0] switch_in;
  logic [WIDTH-1:0] switch_out;
  logic             changed;
  logic [WIDTH-1:0] changed_mask;

  modport master (
    output tick,
    output switch_in,
    input  switch_out,
    input  changed,
    input  changed_mask
  );

  modport slave (
    input  tick,
    input  switch_in,
    output switch_out,
    output changed,
    output changed_mask
  );
endinterface

// File: rtl/switch_debouncer.sv
// Per-bit two-flop synchronizer plus tick-gated stability counter; emits a clean switch value
// and a registered one-cycle change strobe with a per-bit mask.
module switch_debouncer #(
  parameter int unsigned      WIDTH        = 4,
  parameter int unsigned      STABLE_COUNT = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
  input logic               clock,
  input logic               n_reset,
  switch_debouncer_if.slave sw
);
  localparam int unsigned   CW   = $clog2(STABLE_COUNT + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_COUNT - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic             changed_q;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

  // A bit whose synchronized level matches the output is idle and its count is discarded;
  // otherwise it advances on ticks and is accepted on the STABLE_COUNT-th one.
  always_comb begin
    out_d  = out_q;
    mask_d = '0;
    cnt_d  = cnt_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (sync2[i] == out_q[i]) begin
        cnt_d[i] = '0;
      end else if (sw.tick) begin
        if (cnt_q[i] == LAST) begin
          out_d[i]  = sync2[i];
          mask_d[i] = 1'b1;
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      sync1     <= RESET_VALUE;
      sync2     <= RESET_VALUE;
      out_q     <= RESET_VALUE;
      mask_q    <= '0;
      changed_q <= 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1     <= sw.switch_in;
      sync2     <= sync1;
      out_q     <= out_d;
      mask_q    <= mask_d;
      changed_q <= |mask_d;
      cnt_q     <= cnt_d;
    end
  end

  assign sw.switch_out   = out_q;
  assign sw.changed      = changed_q;
  assign sw.changed_mask = mask_q;
endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: vector table, hand-written corner sequences and random stimulus
// against a cycle-level reference model, on a STABLE_COUNT=4 and a STABLE_COUNT=1 instance.
module tb_switch_debouncer;
  localparam int W = 4;

  logic clock = 1'b0;
  logic n_reset;

  switch_debouncer_if #(.WIDTH(W)) ifa ();
  switch_debouncer_if #(.WIDTH(W)) ifb ();

  switch_debouncer #(.WIDTH(W), .STABLE_COUNT(4), .RESET_VALUE(4'b0000)) dut_a (
    .clock  (clock),
    .n_reset(n_reset),
    .sw     (ifa)
  );

  switch_debouncer #(.WIDTH(W), .STABLE_COUNT(1), .RESET_VALUE(4'b0000)) dut_b (
    .clock  (clock),
    .n_reset(n_reset),
    .sw     (ifb)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: synchronizer as a two-stage delay, per-bit count of ticks seen
  // while the delayed level disagrees with the accepted value.
  logic [W-1:0] m_s1   [2];
  logic [W-1:0] m_s2   [2];
  logic [W-1:0] m_out  [2];
  logic [W-1:0] m_mask [2];
  int           run    [2][W];
  int           sc     [2] = '{4, 1};

  typedef struct {
    logic         tick;
    logic [W-1:0] din;
    logic [W-1:0] out;
    logic         chg;
    logic [W-1:0] mask;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic tk, logic [W-1:0] din, logic [W-1:0] out, logic chg,
                              logic [W-1:0] mask);
    vec_t v;
    v.tick = tk; v.din = din; v.out = out; v.chg = chg; v.mask = mask;
    return v;
  endfunction

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(string name, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_s1[d] = '0; m_s2[d] = '0; m_out[d] = '0; m_mask[d] = '0;
      for (int i = 0; i < W; i++) run[d][i] = 0;
    end
  endtask

  task automatic model_edge(int d, logic tk, logic [W-1:0] din);
    m_mask[d] = '0;
    for (int i = 0; i < W; i++) begin
      if (m_s2[d][i] == m_out[d][i]) run[d][i] = 0;
      else if (tk) begin
        run[d][i] = run[d][i] + 1;
        if (run[d][i] == sc[d]) begin
          m_out[d][i]  = m_s2[d][i];
          m_mask[d][i] = 1'b1;
          run[d][i]    = 0;
        end
      end
    end
    m_s2[d] = m_s1[d];
    m_s1[d] = din;
  endtask

  task automatic cycle();
    @(posedge clock);
    if (n_reset) begin
      model_edge(0, ifa.tick, ifa.switch_in);
      model_edge(1, ifb.tick, ifb.switch_in);
    end
    #1;
    chk("a_out_model", ifa.switch_out, m_out[0]);
    chk("a_mask_model", ifa.changed_mask, m_mask[0]);
    chk1("a_chg_model", ifa.changed, |m_mask[0]);
    chk("b_out_model", ifb.switch_out, m_out[1]);
    chk("b_mask_model", ifb.changed_mask, m_mask[1]);
    chk1("b_chg_model", ifb.changed, |m_mask[1]);
  endtask

  initial begin
    int   nt;
    logic done;
    logic exp;

    n_reset       = 1'b0;
    ifa.tick      = 1'b1;
    ifa.switch_in = 4'b0110;
    ifb.tick      = 1'b1;
    ifb.switch_in = 4'b0000;
    model_reset();

    #3;
    chk("rst_a_out", ifa.switch_out, 4'b0000);
    chk1("rst_a_chg", ifa.changed, 1'b0);
    chk("rst_a_mask", ifa.changed_mask, 4'b0000);
    chk("rst_b_out", ifb.switch_out, 4'b0000);
    #7 n_reset = 1'b1;

    // Reset release latency, then a 3-cycle glitch on bit 0.
    for (int k = 1; k <= 5; k++) tbl.push_back(mk(1'b1, 4'b0110, 4'b0000, 1'b0, 4'b0000));
    tbl.push_back(mk(1'b1, 4'b0110, 4'b0110, 1'b1, 4'b0110));
    tbl.push_back(mk(1'b1, 4'b0110, 4'b0110, 1'b0, 4'b0000));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1'b1, 4'b0111, 4'b0110, 1'b0, 4'b0000));
    for (int k = 0; k < 8; k++) tbl.push_back(mk(1'b1, 4'b0110, 4'b0110, 1'b0, 4'b0000));
    foreach (tbl[i]) begin
      ifa.tick      = tbl[i].tick;
      ifa.switch_in = tbl[i].din;
      cycle();
      chk("tbl_out", ifa.switch_out, tbl[i].out);
      chk1("tbl_chg", ifa.changed, tbl[i].chg);
      chk("tbl_mask", ifa.changed_mask, tbl[i].mask);
    end

    // Tick one cycle in three; bit 3 steps high.
    ifa.switch_in = 4'b1110;
    nt   = 0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      ifa.tick = (k % 3 == 0);
      cycle();
      if (k >= 2 && ifa.tick) nt++;
      exp = !done && k >= 2 && ifa.tick && nt == 4;
      chk1("gate_chg", ifa.changed, exp);
      if (exp) begin
        chk("gate_mask", ifa.changed_mask, 4'b1000);
        done = 1'b1;
      end
    end
    chk1("gate_done", done, 1'b1);
    ifa.tick = 1'b1;

    // Staggered rises, then a simultaneous fall.
    ifa.switch_in = 4'b1000;
    repeat (8) cycle();
    for (int k = 0; k < 10; k++) begin
      if (k == 0) ifa.switch_in = 4'b1010;
      if (k == 2) ifa.switch_in = 4'b1110;
      cycle();
      chk1("stag_chg", ifa.changed, k == 5 || k == 7);
      chk("stag_mask", ifa.changed_mask, (k == 5) ? 4'b0010 : (k == 7) ? 4'b0100 : 4'b0000);
    end
    for (int k = 0; k < 10; k++) begin
      if (k == 0) ifa.switch_in = 4'b1000;
      cycle();
      chk1("both_chg", ifa.changed, k == 5);
      chk("both_mask", ifa.changed_mask, (k == 5) ? 4'b0110 : 4'b0000);
    end

    // Reset while bit 0 is pending with two ticks counted.
    ifa.switch_in = 4'b1001;
    repeat (4) cycle();
    #2 n_reset = 1'b0;
    model_reset();
    #1;
    chk("midrst_out", ifa.switch_out, 4'b0000);
    chk1("midrst_chg", ifa.changed, 1'b0);
    chk("midrst_mask", ifa.changed_mask, 4'b0000);
    @(posedge clock);
    #3 n_reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("post_rst_out", ifa.switch_out, (k >= 5) ? 4'b1001 : 4'b0000);
      chk1("post_rst_chg", ifa.changed, k == 5);
      chk("post_rst_mask", ifa.changed_mask, (k == 5) ? 4'b1001 : 4'b0000);
    end

    // STABLE_COUNT=1: only the synchronizer delay remains.
    ifb.switch_in = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("sc1_out", ifb.switch_out, (k >= 2) ? 4'b0100 : 4'b0000);
      chk1("sc1_chg", ifb.changed, k == 2);
    end

    // Random toggling and tick patterns on both instances.
    repeat (400) begin
      if ($urandom_range(5) == 0) ifa.switch_in[$urandom_range(W - 1)] ^= 1'b1;
      if ($urandom_range(3) == 0) ifb.switch_in[$urandom_range(W - 1)] ^= 1'b1;
      ifa.tick = ($urandom_range(2) != 0);
      ifb.tick = ($urandom_range(1) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
